// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared widths and packed-payload layout for the EX->MEM pipeline stage.
// Payload layout (LSB first): mem_w, mem_r, wb, dest, val_Rm, alu_res.
package ex_mem_skid_stage_pkg;

    localparam int REGISTER_LEN    = 32;
    localparam int REG_ADDRESS_LEN = 4;

    localparam int CTRL_LEN  = 3;
    localparam int MEM_W_BIT = 0;
    localparam int MEM_R_BIT = 1;
    localparam int WB_BIT    = 2;
    localparam int DEST_OFS  = CTRL_LEN;

    function automatic int payload_len(input int dw, input int aw);
        return CTRL_LEN + 2 * dw + aw;
    endfunction

    function automatic int val_rm_ofs(input int aw);
        return DEST_OFS + aw;
    endfunction

    function automatic int alu_res_ofs(input int dw, input int aw);
        return DEST_OFS + aw + dw;
    endfunction

    localparam int EX_MEM_PAYLOAD_LEN = payload_len(REGISTER_LEN, REG_ADDRESS_LEN);

endpackage

// File: rtl/ex_mem_skid_stage_payload_reg.sv
// One held pipeline entry: packed payload register with load and a
// control-only clear that turns the entry into a bubble without touching data.
module ex_mem_payload_reg
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int W = EX_MEM_PAYLOAD_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         clr_ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (clr_ctrl) begin
            q[CTRL_LEN-1:0] <= '0;
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage with a 2-entry skid buffer (main + skid); in_ready is a pure
// register output so MEM stalls never form a combinational path into EX.
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int DATA_W = REGISTER_LEN,
    parameter int ADDR_W = REG_ADDRESS_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [ADDR_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_Rm_out,
    output logic [ADDR_W-1:0] dest_out,
    output logic              skid_wb_en,
    output logic [ADDR_W-1:0] skid_dest,
    output logic [1:0]        occupancy
);

    localparam int PW      = payload_len(DATA_W, ADDR_W);
    localparam int VRM_OFS = val_rm_ofs(ADDR_W);
    localparam int ALU_OFS = alu_res_ofs(DATA_W, ADDR_W);

    logic          skid_valid;
    logic          out_valid_nxt, skid_valid_nxt;
    logic          main_ld, main_clr, skid_ld, skid_clr, drain;
    logic          in_fire, out_fire;
    logic [PW-1:0] in_payload, main_d, main_q, skid_q;

    assign in_payload = {alu_res_in, val_Rm_in, dest_in, wb_en_in, mem_r_en_in, mem_w_en_in};
    assign in_fire    = in_valid & ~skid_valid;
    assign out_fire   = out_valid & out_ready;
    assign main_d     = drain ? skid_q : in_payload;

    always_comb begin
        out_valid_nxt  = out_valid;
        skid_valid_nxt = skid_valid;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        drain          = 1'b0;
        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
            main_clr       = 1'b1;
            skid_clr       = 1'b1;
        end else if (skid_valid && out_fire) begin
            // Emptied skid is also cleared so its control bits read as a bubble.
            drain          = 1'b1;
            main_ld        = 1'b1;
            skid_clr       = 1'b1;
            skid_valid_nxt = 1'b0;
        end else if (in_fire) begin
            if (!out_valid || out_ready) begin
                main_ld       = 1'b1;
                out_valid_nxt = 1'b1;
            end else begin
                skid_ld        = 1'b1;
                skid_valid_nxt = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_nxt = 1'b0;
            main_clr      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            occupancy  <= 2'd0;
        end else begin
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready   <= ~skid_valid_nxt;
            occupancy  <= {1'b0, out_valid_nxt} + {1'b0, skid_valid_nxt};
        end
    end

    ex_mem_payload_reg #(.W(PW)) u_main (
        .clk      (clk),
        .rst      (rst),
        .ld       (main_ld),
        .clr_ctrl (main_clr),
        .d        (main_d),
        .q        (main_q)
    );

    ex_mem_payload_reg #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .ld       (skid_ld),
        .clr_ctrl (skid_clr),
        .d        (in_payload),
        .q        (skid_q)
    );

    assign wb_en_out    = main_q[WB_BIT];
    assign mem_r_en_out = main_q[MEM_R_BIT];
    assign mem_w_en_out = main_q[MEM_W_BIT];
    assign dest_out     = main_q[DEST_OFS +: ADDR_W];
    assign val_Rm_out   = main_q[VRM_OFS +: DATA_W];
    assign alu_res_out  = main_q[ALU_OFS +: DATA_W];

    // Skid data holds after a drain, so the hazard view is masked by valid.
    assign skid_wb_en = skid_valid & skid_q[WB_BIT];
    assign skid_dest  = skid_valid ? skid_q[DEST_OFS +: ADDR_W] : '0;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Randomized and directed bench for ex_mem_skid_stage against a 2-deep FIFO
// reference model of the stage.
module tb_ex_mem_skid_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] val;
        logic [ADDR_W-1:0] dest;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, in_valid, out_ready;
    item_t             cur;
    logic              in_ready, out_valid;
    logic              wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [DATA_W-1:0] alu_res_out, val_Rm_out;
    logic [ADDR_W-1:0] dest_out, skid_dest;
    logic              skid_wb_en;
    logic [1:0]        occupancy;

    ex_mem_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wb_en_in     (cur.wb),
        .mem_r_en_in  (cur.mr),
        .mem_w_en_in  (cur.mw),
        .alu_res_in   (cur.alu),
        .val_Rm_in    (cur.val),
        .dest_in      (cur.dest),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out),
        .alu_res_out  (alu_res_out),
        .val_Rm_out   (val_Rm_out),
        .dest_out     (dest_out),
        .skid_wb_en   (skid_wb_en),
        .skid_dest    (skid_dest),
        .occupancy    (occupancy)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t model_q[$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.wb   = 1'($urandom);
        it.mr   = 1'($urandom);
        it.mw   = 1'($urandom);
        it.alu  = $urandom;
        it.val  = $urandom;
        it.dest = ADDR_W'($urandom);
        return it;
    endfunction

    // Stage behaves as a 2-deep FIFO that accepts only when not full.
    task automatic model_edge();
        bit can_take;
        can_take = (model_q.size() < 2);
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
            if (in_valid && can_take) model_q.push_back(cur);
        end
    endtask

    task automatic check_outputs();
        item_t obs;
        obs = {wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out, val_Rm_out, dest_out};
        check("in_ready", 80'(in_ready), 80'(model_q.size() < 2));
        check("out_valid", 80'(out_valid), 80'(model_q.size() > 0));
        check("occupancy", 80'(occupancy), 80'(model_q.size()));
        if (model_q.size() > 0) check("main_entry", 80'(obs), 80'(model_q[0]));
        else check("main_ctrl_bubble", 80'({wb_en_out, mem_r_en_out, mem_w_en_out}), 80'(0));
        if (model_q.size() == 2)
            check("skid_export", 80'({skid_wb_en, skid_dest}), 80'({model_q[1].wb, model_q[1].dest}));
        else
            check("skid_export_empty", 80'({skid_wb_en, skid_dest}), 80'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_data_zero(input string tag);
        check(tag, 80'({alu_res_out, val_Rm_out, dest_out}), 80'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cur = '0;
        @(negedge clk);
        tick();
        tick();
        check_data_zero("reset_data");
        rst = 1'b0;
        tick();

        // Back-to-back stream with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cur = rand_item();
            cur.alu = DATA_W'(i);
            in_valid = 1'b1;
            tick();
            check("stream_alu", 80'(alu_res_out), 80'(i));
        end
        in_valid = 1'b0;
        tick();

        // Stall: A to main, B to skid, C held by EX until space frees up.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_item(); cur.alu = 32'h10; tick();
        cur = rand_item(); cur.alu = 32'h20; tick();
        cur = rand_item(); cur.alu = 32'h30; tick();
        check("stall_occ", 80'(occupancy), 80'(2));
        check("stall_skid_hold", 80'(alu_res_out), 80'(32'h10));
        out_ready = 1'b1;
        tick();
        check("drain_b", 80'(alu_res_out), 80'(32'h20));
        tick();
        check("drain_c", 80'(alu_res_out), 80'(32'h30));
        in_valid = 1'b0;
        tick();
        tick();

        // Flush with both entries full and a live input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_item(); cur.wb = 1'b1; cur.mw = 1'b1; tick();
        cur = rand_item(); cur.wb = 1'b1; cur.mw = 1'b1; tick();
        cur = rand_item(); cur.alu = 32'hDEAD;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_ctrl", 80'({out_valid, wb_en_out, mem_w_en_out, skid_wb_en}), 80'(0));
        check("flush_ready", 80'(in_ready), 80'(1));
        out_ready = 1'b1;
        tick();
        tick();

        // Hazard export of the skid entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_item(); tick();
        cur = rand_item(); cur.wb = 1'b1; cur.dest = 4'd5; tick();
        in_valid = 1'b0;
        check("hazard_skid", 80'({skid_wb_en, skid_dest}), 80'({1'b1, 4'd5}));
        out_ready = 1'b1;
        tick();
        check("hazard_after_drain", 80'(skid_wb_en), 80'(0));

        // Reset mid-transfer with both entries full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur = rand_item(); tick();
        cur = rand_item(); tick();
        rst = 1'b1;
        tick();
        tick();
        check_data_zero("midstream_reset_data");
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            cur       = rand_item();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
